key_schedule_seq: RTL and testbench
===================================

KEY_SCHEDULE_SEQ -- requirements
Module: key_schedule_seq

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port start, input, 1 bit: one-cycle request to begin expansion.
REQ-004 The block SHALL have the port key, input, 256 bits: cipher key with word 0 at [255:224]; AES-128 uses [255:128], AES-192 uses [255:64], AES-256 uses all bits.
REQ-005 The block SHALL have the port Algorithm, input, 2 bits: 00 = AES-128 (Nk=4, Nr=10), 01 = AES-192 (Nk=6, Nr=12), 10 = AES-256 (Nk=8, Nr=14), 11 reserved.
REQ-006 The block SHALL have the port rk, output, 128 bits: current round key, with word 4r at [127:96].
REQ-007 The block SHALL have the port rk_idx, output, 4 bits: round number r of rk.
REQ-008 The block SHALL have the port rk_valid, output, 1 bit: rk/rk_idx valid this cycle (one-cycle pulse), with no backpressure.
REQ-009 The block SHALL have the port busy, output, 1 bit: expansion in progress.
REQ-010 The block SHALL have the port done, output, 1 bit: one-cycle pulse coincident with the final rk_valid.

Function
REQ-011 The FSM SHALL have states IDLE and GEN; IDLE->GEN on start=1 with Algorithm!=11; GEN->IDLE in the cycle after word 4*Nr+3 is produced.
REQ-012 On the accepting edge, the block SHALL latch key and Algorithm, clear the word counter w to 0, clear the Nk-phase counter, set Rcon=01, and set busy=1.
REQ-013 In GEN, the block SHALL produce exactly one 32-bit word W[w] per cycle, with w incrementing from 0 to 4*(Nr+1)-1 (43/51/59).
REQ-014 For w<Nk: W[w] = key word w.
REQ-015 For w>=Nk: W[w] = W[w-Nk] xor T, with T = W[w-1] by default.
REQ-016 If w mod Nk = 0: T = SubWord(RotWord(W[w-1])) xor {Rcon,00,00,00}, and Rcon is then multiplied by 02 in GF(2^8) (poly 11B).
REQ-017 If Nk=8 and w mod 8 = 4: T = SubWord(W[w-1]).
REQ-018 w mod Nk SHALL be tracked by a wrapping phase counter; no divider.
REQ-019 The last 8 words SHALL be held in a shift window; no full-schedule storage.
REQ-020 When W[4r+3] is registered, the block SHALL, at the same edge, register rk = {W[4r],…,W[4r+3]}, set rk_idx = r, and set rk_valid = 1 for one cycle.
REQ-021 Latency: with start sampled at edge E, round r SHALL be valid after edge E+4r+4.
REQ-022 Round r=Nr SHALL be valid after edge E+4Nr+4; done SHALL assert with it; busy SHALL fall at the following edge.
REQ-023 rk and rk_idx SHALL hold their last values between pulses.
REQ-024 start while busy=1 SHALL be ignored, and the running expansion SHALL be unaffected.
REQ-025 start with Algorithm=11 SHALL be ignored (stay IDLE, no pulses).
REQ-026 key and Algorithm changes during GEN SHALL have no effect, since the latched copies are used.
REQ-027 start asserted in the same cycle that busy falls SHALL be accepted normally.

Reset
REQ-028 When rst=1, the FSM SHALL be set to IDLE, with w, phase, and the window cleared, Rcon=01, and rk=0, rk_idx=0, rk_valid=0, busy=0, done=0 at the next edge.
REQ-029 rst SHALL take priority over start.
REQ-030 rst mid-GEN SHALL abort the expansion; no further rk_valid until a new start.

Configuration
REQ-031 With macro KEYSCHED_LAST_KEY_EN defined, output last_rk [127:0] SHALL be present; it is loaded with rk at the done edge and held until reset or the next done, and is reset to 0, providing the decryption start key.
REQ-032 With KEYSCHED_LAST_KEY_EN undefined, port last_rk and its register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 The bench SHALL cover: AES-128 key 2b7e151628aed2a6abf7158809cf4f3c -> 11 pulses at E+4..E+44; rk_idx 1 = a0fafe1788542cb123a339392a6c7605; rk_idx 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done.
REQ-034 The bench SHALL cover: AES-192 key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> 13 pulses; rk_idx 12 = e98ba06f448c773c8ecc720401002202 at E+52; last_rk equals it when the macro is defined.
REQ-035 The bench SHALL cover: AES-256 key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> 15 pulses; rk_idx 14 = fe4890d1e6188d0b046df344706c631e at E+60.
REQ-036 The bench SHALL cover: start pulsed again at E+10 with a different key -> ignored; outputs match the REQ-033 run exactly.
REQ-037 The bench SHALL cover: rst at E+20 in the middle of AES-128 -> next cycle busy=0 and rk=0; no further pulses; a subsequent start reproduces the REQ-033 run.
REQ-038 The bench SHALL cover: start with Algorithm=11 -> busy stays 0 and no rk_valid for 70 cycles.

Source files
------------

// File: rtl/key_schedule_seq.sv
// Sequential AES key expansion: one 32-bit schedule word per cycle, one 128-bit round key every four words.
// Optional KEYSCHED_LAST_KEY_EN adds last_rk, holding the final round key for use as the decryption start key.
module key_schedule_seq (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [255:0] key,
   input  logic [1:0]   Algorithm,
   output logic [127:0] rk,
   output logic [3:0]   rk_idx,
   output logic         rk_valid,
   output logic         busy,
   output logic         done
`ifdef KEYSCHED_LAST_KEY_EN
   ,
   output logic [127:0] last_rk
`endif
);

   typedef enum logic {IDLE, GEN} state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   state_t        r_state, w_nextState;
   logic [255:0]  r_key;
   logic [1:0]    r_alg;
   logic [5:0]    r_w;
   logic [2:0]    r_phase;
   logic [7:0]    r_rcon;
   logic [31:0]   r_win [8];
   logic [127:0]  r_rk;
   logic [3:0]    r_rkIdx;
   logic          r_rkValid;
   logic          r_done;

   logic          w_accept, w_produce, w_inKey, w_isNk8;
   logic [5:0]    w_nk, w_lastWord;
   logic [2:0]    w_nkMinus1, w_keySel;
   logic [31:0]   w_prev, w_back, w_keyWord, w_subIn, w_sub, w_word;
   logic [127:0]  w_rkNext;

   // Per-variant parameters derived from the latched algorithm; 11 is never latched.
   always_comb begin
      w_nk       = 6'd4;
      w_nkMinus1 = 3'd3;
      w_lastWord = 6'd43;
      case (r_alg)
         2'b01:   begin w_nk = 6'd6; w_nkMinus1 = 3'd5; w_lastWord = 6'd51; end
         2'b10:   begin w_nk = 6'd8; w_nkMinus1 = 3'd7; w_lastWord = 6'd59; end
         default: begin w_nk = 6'd4; w_nkMinus1 = 3'd3; w_lastWord = 6'd43; end
      endcase
   end

   assign w_isNk8   = (r_alg == 2'b10);
   assign w_accept  = (r_state == IDLE) && start && (Algorithm != 2'b11);
   assign w_produce = (r_state == GEN) && (r_w <= w_lastWord);
   assign w_inKey   = (r_w < w_nk);
   assign w_prev    = r_win[0];
   assign w_back    = r_win[w_nkMinus1];
   assign w_keySel  = 3'd7 - r_w[2:0];
   assign w_keyWord = r_key[{w_keySel, 5'd0} +: 32];
   assign w_subIn   = (r_phase == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
   assign w_sub     = {SBOX[w_subIn[31:24]], SBOX[w_subIn[23:16]],
                       SBOX[w_subIn[15:8]],  SBOX[w_subIn[7:0]]};
   assign w_rkNext  = {r_win[2], r_win[1], r_win[0], w_word};

   always_comb begin
      w_word = w_back ^ w_prev;
      if (w_inKey)
         w_word = w_keyWord;
      else if (r_phase == 3'd0)
         w_word = w_back ^ w_sub ^ {r_rcon, 24'h0};
      else if (w_isNk8 && (r_phase == 3'd4))
         w_word = w_back ^ w_sub;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_nextState;
   end

   // GEN stays one extra cycle after the last word so busy drops one edge after done.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_nextState = GEN;
         GEN:     if (!w_produce) w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_key     <= '0;
         r_alg     <= 2'b00;
         r_w       <= '0;
         r_phase   <= '0;
         r_rcon    <= 8'h01;
         for (int i = 0; i < 8; i++) r_win[i] <= '0;
         r_rk      <= '0;
         r_rkIdx   <= '0;
         r_rkValid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_rkValid <= 1'b0;
         r_done    <= 1'b0;
         if (w_accept) begin
            r_key   <= key;
            r_alg   <= Algorithm;
            r_w     <= '0;
            r_phase <= '0;
            r_rcon  <= 8'h01;
         end else if (w_produce) begin
            r_win[0] <= w_word;
            for (int i = 7; i > 0; i--) r_win[i] <= r_win[i-1];
            r_w     <= r_w + 6'd1;
            r_phase <= (r_phase == w_nkMinus1) ? 3'd0 : r_phase + 3'd1;
            if (!w_inKey && (r_phase == 3'd0))
               r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
            if (r_w[1:0] == 2'b11) begin
               r_rk      <= w_rkNext;
               r_rkIdx   <= r_w[5:2];
               r_rkValid <= 1'b1;
               r_done    <= (r_w == w_lastWord);
            end
         end
      end
   end

`ifdef KEYSCHED_LAST_KEY_EN
   logic [127:0] r_lastRk;

   always_ff @(posedge clk) begin
      if (rst)
         r_lastRk <= '0;
      else if (w_produce && (r_w == w_lastWord))
         r_lastRk <= w_rkNext;
   end

   assign last_rk = r_lastRk;
`endif

   assign rk       = r_rk;
   assign rk_idx   = r_rkIdx;
   assign rk_valid = r_rkValid;
   assign done     = r_done;
   assign busy     = (r_state == GEN);

endmodule

// File: tb/tb_key_schedule_seq.sv
// Bench for key_schedule_seq: known-answer table, abort/restart sequences and randomized keys against a FIPS-197 style model.
// Checks last_rk as well when KEYSCHED_LAST_KEY_EN is defined.
module tb_key_schedule_seq;

   logic         clk = 1'b0;
   logic         rst, start;
   logic [255:0] key;
   logic [1:0]   Algorithm;
   logic [127:0] rk;
   logic [3:0]   rk_idx;
   logic         rk_valid, busy, done;
`ifdef KEYSCHED_LAST_KEY_EN
   logic [127:0] last_rk;
`endif

   key_schedule_seq dut (
      .clk(clk), .rst(rst), .start(start), .key(key), .Algorithm(Algorithm),
      .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid), .busy(busy), .done(done)
`ifdef KEYSCHED_LAST_KEY_EN
      , .last_rk(last_rk)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [1:0]   alg;
      logic [255:0] k;
      int           idx;
      logic [127:0] expRk;
      int           expCycle;
   } katVec_t;

   int           vecCount = 0;
   int           missCount = 0;
   logic [7:0]   sboxRef [256];
   logic [31:0]  mW [60];
   logic [127:0] expRk, expLast;
   logic [3:0]   expIdx;
   logic [127:0] captRk [15];
   int           captCycle [15];

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   task automatic checkOutput(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] gfDouble(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= a;
         a = gfDouble(a);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t = {b, b};
      return t[15-n -: 8];
   endfunction

   // S-box rebuilt from its definition: multiplicative inverse followed by the affine map.
   task automatic buildSbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gfMul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sboxRef[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subWordRef(input logic [31:0] w);
      return {sboxRef[w[31:24]], sboxRef[w[23:16]], sboxRef[w[15:8]], sboxRef[w[7:0]]};
   endfunction

   task automatic modelExpand(input logic [1:0] alg, input logic [255:0] k);
      int nk = 4 + 2 * int'(alg);
      int nr = 10 + 2 * int'(alg);
      logic [7:0] rcon = 8'h01;
      logic [31:0] t;
      for (int i = 0; i < nk; i++) mW[i] = k[255 - 32*i -: 32];
      for (int i = nk; i < 4 * (nr + 1); i++) begin
         t = mW[i-1];
         if (i % nk == 0) begin
            t = subWordRef({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
            rcon = gfDouble(rcon);
         end else if (nk == 8 && i % 8 == 4) begin
            t = subWordRef(t);
         end
         mW[i] = mW[i-nk] ^ t;
      end
   endtask

   // Runs one expansion from the current idle state, checking every cycle; optionally re-pulses start or resets mid-run.
   task automatic applyStimulus(input logic [1:0] alg, input logic [255:0] k, input int restartAt,
                                input logic [255:0] altKey, input int rstAt, input bit scramble);
      int nr = 10 + 2 * int'(alg);
      int lastCycle = 4 * nr + 5;
      int pulses = 0;
      bit expValid;
      int r;
      modelExpand(alg, k);
      for (int i = 0; i < 15; i++) begin captRk[i] = 'x; captCycle[i] = -1; end
      key = k; Algorithm = alg; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("busyAtAccept", busy, 1);
      checkOutput("validAtAccept", rk_valid, 0);
      checkOutput("rkHeldAtAccept", rk, expRk);
      for (int c = 1; c <= lastCycle; c++) begin
         if (scramble) begin
            key = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            Algorithm = 2'($urandom_range(0, 3));
         end
         if (c == restartAt) begin start = 1'b1; key = altKey; end
         if (c == rstAt) rst = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
         if (c == rstAt) begin
            rst = 1'b0;
            expRk = '0; expIdx = '0; expLast = '0;
            checkOutput("abortBusy", busy, 0);
            checkOutput("abortRk", rk, 0);
            checkOutput("abortRkIdx", rk_idx, 0);
            checkOutput("abortValid", rk_valid, 0);
            checkOutput("abortDone", done, 0);
            for (int q = 0; q < 70; q++) begin
               @(posedge clk); #1;
               checkOutput("postAbortValid", rk_valid, 0);
               checkOutput("postAbortBusy", busy, 0);
            end
            return;
         end
         expValid = (c % 4 == 0) && (c <= 4 * nr + 4);
         if (expValid) begin
            r = c / 4 - 1;
            expRk = {mW[4*r], mW[4*r+1], mW[4*r+2], mW[4*r+3]};
            expIdx = 4'(r);
            captRk[r] = rk;
            captCycle[r] = c;
         end
         if (rk_valid) pulses++;
         checkOutput("rkValid", rk_valid, expValid);
         checkOutput("busy", busy, c <= 4 * nr + 4);
         checkOutput("done", done, c == 4 * nr + 4);
         checkOutput("rk", rk, expRk);
         checkOutput("rkIdx", rk_idx, expIdx);
         if (c == 4 * nr + 4) expLast = expRk;
`ifdef KEYSCHED_LAST_KEY_EN
         checkOutput("lastRk", last_rk, expLast);
`endif
      end
      checkOutput("pulseCount", pulses, nr + 1);
   endtask

   katVec_t kat [4];

   initial begin
      kat[0] = '{"aes128_r1",  2'd0, K128, 1,  128'ha0fafe1788542cb123a339392a6c7605, 8};
      kat[1] = '{"aes128_r10", 2'd0, K128, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 44};
      kat[2] = '{"aes192_r12", 2'd1, K192, 12, 128'he98ba06f448c773c8ecc720401002202, 52};
      kat[3] = '{"aes256_r14", 2'd2, K256, 14, 128'hfe4890d1e6188d0b046df344706c631e, 60};

      buildSbox();
      expRk = '0; expIdx = '0; expLast = '0;

      // Reset with start held high: reset must win.
      rst = 1'b1; start = 1'b1; key = K128; Algorithm = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; start = 1'b0;
      checkOutput("resetBusy", busy, 0);
      checkOutput("resetValid", rk_valid, 0);
      checkOutput("resetDone", done, 0);
      checkOutput("resetRk", rk, 0);
      checkOutput("resetRkIdx", rk_idx, 0);
`ifdef KEYSCHED_LAST_KEY_EN
      checkOutput("resetLastRk", last_rk, 0);
`endif

      // Known-answer vectors, each from a fresh start.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(kat[i].alg, kat[i].k, -1, '0, -1, 1'b0);
         checkOutput({kat[i].name, "_rk"}, captRk[kat[i].idx], kat[i].expRk);
         checkOutput({kat[i].name, "_cycle"}, captCycle[kat[i].idx], kat[i].expCycle);
      end

      // Second start during GEN must be ignored.
      applyStimulus(2'd0, K128, 10, K256, -1, 1'b0);
      checkOutput("restartIgnored_r1", captRk[1], kat[0].expRk);
      checkOutput("restartIgnored_r10", captRk[10], kat[1].expRk);

      // Reset at E+20 aborts, then a fresh run reproduces the AES-128 schedule.
      applyStimulus(2'd0, K128, -1, '0, 20, 1'b0);
      applyStimulus(2'd0, K128, -1, '0, -1, 1'b0);
      checkOutput("afterAbort_r1", captRk[1], kat[0].expRk);
      checkOutput("afterAbort_r10", captRk[10], kat[1].expRk);

      // Reserved algorithm code: nothing happens for 70 cycles.
      key = K256; Algorithm = 2'b11; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int q = 0; q < 70; q++) begin
         checkOutput("reservedBusy", busy, 0);
         checkOutput("reservedValid", rk_valid, 0);
         checkOutput("reservedRkHeld", rk, expRk);
         @(posedge clk); #1;
      end

      // Random keys and variants, inputs scrambled during GEN, back-to-back or with short gaps.
      for (int n = 0; n < 8; n++) begin
         applyStimulus(2'($urandom_range(0, 2)),
                       {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
                       -1, '0, -1, 1'b1);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
